// File: rtl/gpr_mp_if.sv
// Port bundle for gpr_mp: clear request, two write ports, read ports and the busy-allocate port.
// The master drives requests; the slave returns ready, read data and busy flags.
interface gpr_mp_if #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int NUM_RD = 4
);
   logic                 clr_req;
   logic                 ready;
   logic                 we0;
   logic [AW-1:0]        waddr0;
   logic [DW-1:0]        wdata0;
   logic                 we1;
   logic [AW-1:0]        waddr1;
   logic [DW-1:0]        wdata1;
   logic [NUM_RD-1:0]    re;
   logic [NUM_RD*AW-1:0] raddr;
   logic [NUM_RD*DW-1:0] rdata;
   logic [NUM_RD-1:0]    rbusy;
   logic                 alloc_en;
   logic [AW-1:0]        alloc_addr;

   modport master (
      output clr_req, we0, waddr0, wdata0, we1, waddr1, wdata1,
             re, raddr, alloc_en, alloc_addr,
      input  ready, rdata, rbusy
   );

   modport slave (
      input  clr_req, we0, waddr0, wdata0, we1, waddr1, wdata1,
             re, raddr, alloc_en, alloc_addr,
      output ready, rdata, rbusy
   );
endinterface

// File: rtl/gpr_mp.sv
// Dual-write, NUM_RD-read register file with same-cycle write bypass and per-register busy scoreboard.
// Reads are combinational, writes land at the edge; ready stays low for NUM_REGS-1 cycles while the clear sweep runs.
module gpr_mp #(
   parameter int DW       = 32,
   parameter int NUM_REGS = 32,
   parameter int AW       = 5,
   parameter int NUM_RD   = 4
) (
   input  logic    clk,
   input  logic    rst,
   gpr_mp_if.slave rf
);
   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

   localparam logic [AW-1:0] FIRST_IDX = AW'(1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

   state_e                    state_q, state_d;
   logic [AW-1:0]             cnt_q, cnt_d;
   logic [NUM_REGS-1:0]       busy_q, busy_d;
   logic [DW-1:0]             regs_q [NUM_REGS];

   logic                      ready_s;
   logic                      clr_go;
   logic                      wr0_ok, wr1_ok, alloc_ok;
   logic [NUM_RD-1:0][AW-1:0] raddr_w;
   logic [NUM_RD-1:0][DW-1:0] rdata_s;
   logic [NUM_RD-1:0]         rbusy_s;

   // Register 0 and out-of-range addresses never hold state.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW+1)'(NUM_REGS)) && (a != '0);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR: if (cnt_q == LAST_IDX) state_d = READY;
         READY: if (rf.clr_req)        state_d = CLEAR;
      endcase
   end

   always_comb begin
      ready_s = (state_q == READY) && !rst;
   end

   assign clr_go   = ready_s && rf.clr_req;
   assign wr0_ok   = ready_s && rf.we0      && addr_ok(rf.waddr0);
   assign wr1_ok   = ready_s && rf.we1      && addr_ok(rf.waddr1);
   assign alloc_ok = ready_s && rf.alloc_en && addr_ok(rf.alloc_addr);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
      end else if (clr_go) begin
         cnt_d = FIRST_IDX;
      end
   end

   // Allocation is applied after the write release so a new producer wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_go) begin
         busy_d = '0;
      end else begin
         if (wr0_ok)   busy_d[rf.waddr0]     = 1'b0;
         if (wr1_ok)   busy_d[rf.waddr1]     = 1'b0;
         if (alloc_ok) busy_d[rf.alloc_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= FIRST_IDX;
         busy_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // Port 1 is written last so it wins a same-address conflict.
   always_ff @(posedge clk) begin
      regs_q[0] <= '0;
      if (!rst && state_q == CLEAR) regs_q[cnt_q] <= '0;
      if (wr0_ok) regs_q[rf.waddr0] <= rf.wdata0;
      if (wr1_ok) regs_q[rf.waddr1] <= rf.wdata1;
   end

   assign raddr_w = rf.raddr;

   always_comb begin
      rdata_s = '0;
      rbusy_s = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (ready_s && rf.re[i] && addr_ok(raddr_w[i])) begin
            if (rf.we1 && rf.waddr1 == raddr_w[i]) begin
               rdata_s[i] = rf.wdata1;
            end else if (rf.we0 && rf.waddr0 == raddr_w[i]) begin
               rdata_s[i] = rf.wdata0;
            end else begin
               rdata_s[i] = regs_q[raddr_w[i]];
            end
            rbusy_s[i] = busy_q[raddr_w[i]];
         end
      end
   end

   assign rf.ready = ready_s;
   assign rf.rdata = rdata_s;
   assign rf.rbusy = rbusy_s;

   a_busy0_low: assert property (@(posedge clk) disable iff (rst) !busy_q[0]);
   a_cnt_nonzero_in_clear: assert property (@(posedge clk) disable iff (rst)
      (state_q == CLEAR) |-> (cnt_q != '0));
endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised multi-port general-purpose register file for the core decode/writeback path.
- Two write ports, NUM_RD combinational read ports with same-cycle write-to-read bypass, and a per-register busy scoreboard.
- A hardware clear sequencer zeroes every register after reset or on request.
- Replaces the single-write/dual-read register file for the dual-issue pipeline.

Parameters:
- DW, 32, data width of each register.
- NUM_REGS, 32, number of registers; register 0 is hardwired to zero.
- AW, 5, address width; must equal clog2(NUM_REGS).
- NUM_RD, 4, number of read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr_req  input  1  pulse; restarts the clear sequence when in READY.
- ready  output  1  high when register contents are valid and writes are accepted.
- we0  input  1  write enable, port 0 (older instruction).
- waddr0  input  AW  write address, port 0.
- wdata0  input  DW  write data, port 0.
- we1  input  1  write enable, port 1 (younger instruction).
- waddr1  input  AW  write address, port 1.
- wdata1  input  DW  write data, port 1.
- re  input  NUM_RD  per-port read enable.
- raddr  input  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rdata  output  NUM_RD*DW  packed read data.
- rbusy  output  NUM_RD  per-port busy flag of the addressed register.
- alloc_en  input  1  mark a destination register busy.
- alloc_addr  input  AW  register to mark busy.

Behaviour:
- FSM has two states, CLEAR and READY.
- Reset:
  - rst=1 at a clock edge: state<=CLEAR, clear counter cnt<=1, all busy bits<=0.
  - While rst is high: ready=0, rdata=0, rbusy=0.
- CLEAR:
  - Each cycle: regs[cnt]<=0 and cnt<=cnt+1.
  - When cnt==NUM_REGS-1, that register is cleared and state<=READY.
  - Duration is NUM_REGS-1 cycles; ready goes high on the following cycle.
  - Write ports are ignored; alloc_en is ignored.
  - All rdata=0, all rbusy=0.
- READY: ready=1.
  - clr_req=1: state<=CLEAR, cnt<=1, all busy bits cleared. Writes in that same cycle still commit.
  - clr_req while already in CLEAR: ignored; the sequence does not restart.
- Writes (READY only):
  - Committed at the clock edge when weN=1 and waddrN!=0.
  - If we0 and we1 target the same non-zero address, port 1 data is stored.
  - Writes to address 0 are discarded.
- Reads, combinational, evaluated per port i:
  - Checked in order; the first matching rule applies:
    1. rst=1, state!=READY, re[i]=0, or raddr_i==0: rdata_i=0.
    2. we1=1 and waddr1==raddr_i: rdata_i=wdata1.
    3. we0=1 and waddr0==raddr_i: rdata_i=wdata0.
    4. Otherwise: rdata_i=regs[raddr_i].
  - Rules 2 and 3 are the same-cycle bypass; port 1 has priority over port 0.
- Scoreboard:
  - busy[NUM_REGS] is reset/clear to 0; busy[0] is always 0.
  - At the clock edge, a valid write clears busy[waddrN].
  - alloc_en=1 with alloc_addr!=0 sets busy[alloc_addr].
  - If the same address is both written and allocated in one cycle, set wins: a new producer supersedes the old one.
  - rbusy[i]=busy[raddr_i] & re[i] & ready.
  - rbusy is not bypassed: a write in the current cycle still shows busy until the next edge, and bypassed data is available regardless.
- Reset mid-CLEAR restarts the sequence at cnt=1. Reset in READY discards any in-flight write at that edge.
- Address values >= NUM_REGS (non-power-of-2 NUM_REGS) are ignored for writes and read as 0.

Test Plan:
- Clear sequence: assert rst for 1 cycle with defaults → ready=0 for exactly 31 cycles after rst drops, then 1; every register reads 0x0.
- Dual write, different addresses: we0 r3=0x11, we1 r4=0x22 → next cycle raddr{3,4} read 0x11/0x22.
- Same-address conflict: we0 r5=0xAAAA and we1 r5=0xBBBB together → same-cycle bypass on raddr=5 gives 0xBBBB; next cycle reads 0xBBBB.
- Register 0: write 0xDEAD to r0 on both ports, read r0 on all ports → 0x0; alloc r0 → rbusy=0.
- Scoreboard: alloc r7, next cycle rbusy=1; write r7=0x7 with alloc r7 in same cycle → busy stays 1; write r7 alone → busy 0 next cycle, read 0x7.
- clr_req in READY with a we0 write r9=0x9 in the same cycle → ready low for 31 cycles; afterwards r9 reads 0; writes during CLEAR are dropped.
